// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded operands and control for EX.
// Handles load-use bubbles, branch flushes (deferred across a hold), freezes, and hazard counters.
module id_ex_stage_reg #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ID_EX_stall,
   input  logic              ID_EX_flush,
   input  logic              hold,
   input  logic [DATA_W-1:0] IR_IF_ID_out,
   input  logic [DATA_W-1:0] PC_IF_ID_out,
   input  logic [DATA_W-1:0] rs_data_in,
   input  logic [DATA_W-1:0] rt_data_in,
   input  logic [DATA_W-1:0] imm_ext_in,
   input  logic [11:0]       ctrl_in,
   output logic [DATA_W-1:0] IR_ID_EX_out,
   output logic [DATA_W-1:0] PC_ID_EX_out,
   output logic [DATA_W-1:0] rs_data_out,
   output logic [DATA_W-1:0] rt_data_out,
   output logic [DATA_W-1:0] imm_ext_out,
   output logic [11:0]       ctrl_out,
   output logic              MemRead_ID_EX_out,
   output logic              valid_ID_EX_out,
   output logic [CNT_W-1:0]  bubble_count,
   output logic [CNT_W-1:0]  flush_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic flush_pending;
   logic do_flush;

   // A flush seen during a hold is remembered and applied on the first released edge.
   assign do_flush = ID_EX_flush | flush_pending;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         IR_ID_EX_out    <= '0;
         PC_ID_EX_out    <= '0;
         rs_data_out     <= '0;
         rt_data_out     <= '0;
         imm_ext_out     <= '0;
         ctrl_out        <= '0;
         valid_ID_EX_out <= 1'b0;
         bubble_count    <= '0;
         flush_count     <= '0;
         flush_pending   <= 1'b0;
      end else if (hold) begin
         if (ID_EX_flush)
            flush_pending <= 1'b1;
      end else if (do_flush) begin
         IR_ID_EX_out    <= '0;
         PC_ID_EX_out    <= '0;
         rs_data_out     <= '0;
         rt_data_out     <= '0;
         imm_ext_out     <= '0;
         ctrl_out        <= '0;
         valid_ID_EX_out <= 1'b0;
         flush_pending   <= 1'b0;
         if (flush_count != CNT_MAX)
            flush_count <= flush_count + 1'b1;
      end else if (ID_EX_stall) begin
         IR_ID_EX_out    <= '0;
         PC_ID_EX_out    <= '0;
         rs_data_out     <= '0;
         rt_data_out     <= '0;
         imm_ext_out     <= '0;
         ctrl_out        <= '0;
         valid_ID_EX_out <= 1'b0;
         if (bubble_count != CNT_MAX)
            bubble_count <= bubble_count + 1'b1;
      end else begin
         IR_ID_EX_out    <= IR_IF_ID_out;
         PC_ID_EX_out    <= PC_IF_ID_out;
         rs_data_out     <= rs_data_in;
         rt_data_out     <= rt_data_in;
         imm_ext_out     <= imm_ext_in;
         ctrl_out        <= ctrl_in;
         valid_ID_EX_out <= 1'b1;
      end
   end

   assign MemRead_ID_EX_out = ctrl_out[10];

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg using a cycle-level reference model.
// Counters are instantiated 4 bits wide so saturation is reachable quickly.
module tb_id_ex_stage_reg;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset;
   logic ID_EX_stall, ID_EX_flush, hold;
   logic [DATA_W-1:0] IR_IF_ID_out, PC_IF_ID_out, rs_data_in, rt_data_in, imm_ext_in;
   logic [11:0] ctrl_in;
   logic [DATA_W-1:0] IR_ID_EX_out, PC_ID_EX_out, rs_data_out, rt_data_out, imm_ext_out;
   logic [11:0] ctrl_out;
   logic MemRead_ID_EX_out, valid_ID_EX_out;
   logic [CNT_W-1:0] bubble_count, flush_count;

   id_ex_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .ID_EX_stall(ID_EX_stall), .ID_EX_flush(ID_EX_flush), .hold(hold),
      .IR_IF_ID_out(IR_IF_ID_out), .PC_IF_ID_out(PC_IF_ID_out),
      .rs_data_in(rs_data_in), .rt_data_in(rt_data_in), .imm_ext_in(imm_ext_in),
      .ctrl_in(ctrl_in),
      .IR_ID_EX_out(IR_ID_EX_out), .PC_ID_EX_out(PC_ID_EX_out),
      .rs_data_out(rs_data_out), .rt_data_out(rt_data_out), .imm_ext_out(imm_ext_out),
      .ctrl_out(ctrl_out), .MemRead_ID_EX_out(MemRead_ID_EX_out),
      .valid_ID_EX_out(valid_ID_EX_out),
      .bubble_count(bubble_count), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state: what the stage should hold after each edge.
   logic [DATA_W-1:0] m_ir, m_pc, m_rs, m_rt, m_imm;
   logic [11:0] m_ctrl;
   logic m_valid, m_pend;
   int m_bc, m_fc;

   function automatic void model_reset();
      m_ir = '0; m_pc = '0; m_rs = '0; m_rt = '0; m_imm = '0; m_ctrl = '0;
      m_valid = 1'b0; m_pend = 1'b0; m_bc = 0; m_fc = 0;
   endfunction

   function automatic void model_nop();
      m_ir = '0; m_pc = '0; m_rs = '0; m_rt = '0; m_imm = '0; m_ctrl = '0;
      m_valid = 1'b0;
   endfunction

   function automatic void model_edge();
      if (hold) begin
         if (ID_EX_flush) m_pend = 1'b1;
      end else if (ID_EX_flush || m_pend) begin
         model_nop();
         m_pend = 1'b0;
         m_fc = (m_fc < CNT_MAX) ? m_fc + 1 : CNT_MAX;
      end else if (ID_EX_stall) begin
         model_nop();
         m_bc = (m_bc < CNT_MAX) ? m_bc + 1 : CNT_MAX;
      end else begin
         m_ir = IR_IF_ID_out; m_pc = PC_IF_ID_out; m_rs = rs_data_in;
         m_rt = rt_data_in; m_imm = imm_ext_in; m_ctrl = ctrl_in; m_valid = 1'b1;
      end
   endfunction

   task automatic drive(input logic st, input logic fl, input logic hd,
                        input logic [DATA_W-1:0] ir, input logic [11:0] ctrl);
      ID_EX_stall = st; ID_EX_flush = fl; hold = hd;
      IR_IF_ID_out = ir; ctrl_in = ctrl;
      PC_IF_ID_out = $urandom; rs_data_in = $urandom;
      rt_data_in = $urandom; imm_ext_in = $urandom;
   endtask

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 12'h0);
      model_reset();
      #12;
      checks++;
      if (IR_ID_EX_out !== 32'h0 || valid_ID_EX_out !== 1'b0 || MemRead_ID_EX_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_initial ir=%h valid=%b memread=%b expected 0", IR_ID_EX_out, valid_ID_EX_out, MemRead_ID_EX_out);
      end
      @(negedge clk);
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 12'hFFF);
      tick();
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      checks++;
      if ({IR_ID_EX_out, PC_ID_EX_out, rs_data_out, rt_data_out, imm_ext_out, ctrl_out} !== '0 ||
          MemRead_ID_EX_out !== 1'b0 || valid_ID_EX_out !== 1'b0 ||
          bubble_count !== '0 || flush_count !== '0) begin
         errors++;
         $display("FAIL reset_async ir=%h ctrl=%h memread=%b valid=%b bc=%0d fc=%0d expected all 0",
                  IR_ID_EX_out, ctrl_out, MemRead_ID_EX_out, valid_ID_EX_out, bubble_count, flush_count);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_normal();
      drive(1'b0, 1'b0, 1'b0, 32'h8C880004, 12'h600);
      tick();
      checks++;
      if (IR_ID_EX_out !== 32'h8C880004 || MemRead_ID_EX_out !== 1'b1 || valid_ID_EX_out !== 1'b1 ||
          ctrl_out !== 12'h600 || rs_data_out !== m_rs) begin
         errors++;
         $display("FAIL normal_load ir=%h memread=%b valid=%b ctrl=%h expected ir=8c880004 memread=1 valid=1 ctrl=600",
                  IR_ID_EX_out, MemRead_ID_EX_out, valid_ID_EX_out, ctrl_out);
      end
   endtask

   task automatic test_bubble();
      for (int i = 1; i <= 2; i++) begin
         drive(1'b1, 1'b0, 1'b0, 32'h01095020, 12'h9A3);
         tick();
         checks++;
         if (IR_ID_EX_out !== 32'h0 || valid_ID_EX_out !== 1'b0 || ctrl_out !== 12'h0 ||
             bubble_count !== CNT_W'(i)) begin
            errors++;
            $display("FAIL bubble_%0d ir=%h valid=%b bc=%0d expected ir=0 valid=0 bc=%0d",
                     i, IR_ID_EX_out, valid_ID_EX_out, bubble_count, i);
         end
      end
      drive(1'b0, 1'b0, 1'b0, 32'h01095020, 12'h9A3);
      tick();
      checks++;
      if (IR_ID_EX_out !== 32'h01095020 || valid_ID_EX_out !== 1'b1 || bubble_count !== 4'd2) begin
         errors++;
         $display("FAIL bubble_release ir=%h valid=%b bc=%0d expected ir=01095020 valid=1 bc=2",
                  IR_ID_EX_out, valid_ID_EX_out, bubble_count);
      end
   endtask

   task automatic test_deferred_flush();
      drive(1'b0, 1'b1, 1'b1, 32'h12345678, 12'h400);
      tick();
      checks++;
      if (IR_ID_EX_out !== 32'h01095020 || valid_ID_EX_out !== 1'b1 || flush_count !== 4'd0) begin
         errors++;
         $display("FAIL flush_held ir=%h valid=%b fc=%0d expected ir=01095020 valid=1 fc=0",
                  IR_ID_EX_out, valid_ID_EX_out, flush_count);
      end
      drive(1'b0, 1'b0, 1'b0, 32'h12345678, 12'h400);
      tick();
      checks++;
      if (IR_ID_EX_out !== 32'h0 || valid_ID_EX_out !== 1'b0 || flush_count !== 4'd1) begin
         errors++;
         $display("FAIL flush_deferred ir=%h valid=%b fc=%0d expected ir=0 valid=0 fc=1",
                  IR_ID_EX_out, valid_ID_EX_out, flush_count);
      end
      drive(1'b0, 1'b0, 1'b0, 32'h12345678, 12'h400);
      tick();
      checks++;
      if (IR_ID_EX_out !== 32'h12345678 || valid_ID_EX_out !== 1'b1 || flush_count !== 4'd1 ||
          MemRead_ID_EX_out !== 1'b1) begin
         errors++;
         $display("FAIL flush_after ir=%h valid=%b fc=%0d expected ir=12345678 valid=1 fc=1",
                  IR_ID_EX_out, valid_ID_EX_out, flush_count);
      end
   endtask

   task automatic test_collision();
      drive(1'b1, 1'b1, 1'b0, 32'hAAAA5555, 12'hFFF);
      tick();
      checks++;
      if (IR_ID_EX_out !== 32'h0 || valid_ID_EX_out !== 1'b0 || flush_count !== 4'd2 ||
          bubble_count !== 4'd2) begin
         errors++;
         $display("FAIL flush_stall ir=%h valid=%b fc=%0d bc=%0d expected ir=0 valid=0 fc=2 bc=2",
                  IR_ID_EX_out, valid_ID_EX_out, flush_count, bubble_count);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b0, 1'b0, $urandom, 12'($urandom));
         tick();
      end
      checks++;
      if (bubble_count !== 4'd15 || valid_ID_EX_out !== 1'b0) begin
         errors++;
         $display("FAIL bubble_saturate bc=%0d valid=%b expected bc=15 valid=0", bubble_count, valid_ID_EX_out);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         drive($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
               $urandom, 12'($urandom));
         tick();
         checks++;
         if ({IR_ID_EX_out, PC_ID_EX_out, rs_data_out, rt_data_out, imm_ext_out, ctrl_out,
              MemRead_ID_EX_out, valid_ID_EX_out} !==
             {m_ir, m_pc, m_rs, m_rt, m_imm, m_ctrl, m_ctrl[10], m_valid}) begin
            errors++;
            $display("FAIL random_data cyc=%0d ir=%h pc=%h ctrl=%h valid=%b expected ir=%h pc=%h ctrl=%h valid=%b",
                     i, IR_ID_EX_out, PC_ID_EX_out, ctrl_out, valid_ID_EX_out, m_ir, m_pc, m_ctrl, m_valid);
         end
         checks++;
         if (bubble_count !== CNT_W'(m_bc) || flush_count !== CNT_W'(m_fc)) begin
            errors++;
            $display("FAIL random_counts cyc=%0d bc=%0d fc=%0d expected bc=%0d fc=%0d",
                     i, bubble_count, flush_count, m_bc, m_fc);
         end
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_bubble();
      test_deferred_flush();
      test_collision();
      test_saturation();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
